sb_ram_40_4k: RTL and testbench

SB_RAM_40_4K -- requirements
Module: sb_ram_40_4k

---
 rtl/sb_ram_40_4k.sv | 71 +++++++
 tb/tb_sb_ram_40_4k.sv | 124 ++++++++++++
 2 files changed

// File: rtl/sb_ram_40_4k.sv
// sb_ram_40_4k: 4Kbit dual-geometry block RAM, registered read, optional SB_RAM_WRITE_MASK_EN bit mask
module sb_ram_40_4k #(
  parameter int READ_MODE = 0,
  parameter int WRITE_MODE = 0,
  parameter logic [255:0] INIT_0 = 256'h0,
  parameter logic [255:0] INIT_1 = 256'h0,
  parameter logic [255:0] INIT_2 = 256'h0,
  parameter logic [255:0] INIT_3 = 256'h0,
  parameter logic [255:0] INIT_4 = 256'h0,
  parameter logic [255:0] INIT_5 = 256'h0,
  parameter logic [255:0] INIT_6 = 256'h0,
  parameter logic [255:0] INIT_7 = 256'h0,
  parameter logic [255:0] INIT_8 = 256'h0,
  parameter logic [255:0] INIT_9 = 256'h0,
  parameter logic [255:0] INIT_A = 256'h0,
  parameter logic [255:0] INIT_B = 256'h0,
  parameter logic [255:0] INIT_C = 256'h0,
  parameter logic [255:0] INIT_D = 256'h0,
  parameter logic [255:0] INIT_E = 256'h0,
  parameter logic [255:0] INIT_F = 256'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] raddr,
  input  logic        re,
  input  logic        rclke,
  output logic [15:0] rdata,
  input  logic [10:0] waddr,
  input  logic [15:0] wdata,
  input  logic        we,
  input  logic        wclke,
  input  logic [15:0] mask
);
  localparam int RW = 16 >> READ_MODE;
  localparam int WW = 16 >> WRITE_MODE;
  localparam int RA = 8 + READ_MODE;
  localparam int WA = 8 + WRITE_MODE;
  localparam int RS = 1 << READ_MODE;
  localparam int WS = 1 << WRITE_MODE;
  localparam int RO = READ_MODE == 0 ? 0 : RS / 2 - 1;
  localparam int WO = WRITE_MODE == 0 ? 0 : WS / 2 - 1;
  logic [4095:0] mem = {INIT_F, INIT_E, INIT_D, INIT_C, INIT_B, INIT_A, INIT_9, INIT_8,
                        INIT_7, INIT_6, INIT_5, INIT_4, INIT_3, INIT_2, INIT_1, INIT_0};
  logic [RW-1:0] rword;
  logic [WW-1:0] wold, wword, wkeep;
  logic [15:0] rlanes;
  logic unused;
  int ri, wi;
  assign ri = int'(raddr[RA-1:0]) * RW;
  assign wi = int'(waddr[WA-1:0]) * WW;
  assign rword = mem[ri +: RW];
  assign wold = mem[wi +: WW];
  assign unused = ^{raddr, waddr, wdata, mask};
  // Narrow words sit on spread-out data lanes: word bit j <-> lane j*stride+offset
  always_comb begin
    rlanes = '0;
    wword = '0;
    for (int j = 0; j < RW; j++) rlanes[j*RS+RO] = rword[j];
    for (int j = 0; j < WW; j++) wword[j] = wdata[j*WS+WO];
  end
`ifdef SB_RAM_WRITE_MASK_EN
  assign wkeep = WRITE_MODE == 0 ? mask[WW-1:0] : '0;
`else
  assign wkeep = '0;
`endif
  always_ff @(posedge clk) begin
    if (rst) rdata <= '0;
    else if (rclke && re) rdata <= rlanes;
    if (!rst && wclke && we) mem[wi +: WW] <= (wold & wkeep) | (wword & ~wkeep);
  end
endmodule

// File: tb/tb_sb_ram_40_4k.sv
// tb_sb_ram_40_4k: four geometries driven in parallel, checked against a bit-array model
module tb_sb_ram_40_4k;
  localparam logic [255:0] INIT1 = {256{1'b1}};
  localparam logic [255:0] INIT2 = {8{32'hC3A5_1E7F}};
  localparam int RM [4] = '{0, 3, 2, 1};
  localparam int WM [4] = '{0, 0, 1, 3};
  logic clk = 0;
  logic rst, re, rclke, we, wclke;
  logic [10:0] raddr, waddr;
  logic [15:0] wdata, mask;
  logic [15:0] rd [4];
  logic [15:0] rexp [4];
  bit m [4][4096];
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  sb_ram_40_4k u0 (.clk, .rst, .raddr, .re, .rclke, .rdata(rd[0]), .waddr, .wdata, .we, .wclke, .mask);
  sb_ram_40_4k #(.READ_MODE(3), .WRITE_MODE(0), .INIT_0(INIT1)) u1 (.clk, .rst, .raddr, .re, .rclke,
    .rdata(rd[1]), .waddr, .wdata, .we, .wclke, .mask);
  sb_ram_40_4k #(.READ_MODE(2), .WRITE_MODE(1), .INIT_5(INIT2)) u2 (.clk, .rst, .raddr, .re, .rclke,
    .rdata(rd[2]), .waddr, .wdata, .we, .wclke, .mask);
  sb_ram_40_4k #(.READ_MODE(1), .WRITE_MODE(3)) u3 (.clk, .rst, .raddr, .re, .rclke,
    .rdata(rd[3]), .waddr, .wdata, .we, .wclke, .mask);
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic int lane(input int md, input int j);
    return md == 0 ? j : md == 1 ? 2 * j : md == 2 ? 4 * j + 1 : 8 * j + 3;
  endfunction
  function automatic logic [15:0] mread(input int k, input logic [10:0] a);
    int w = 16 >> RM[k];
    int wa = int'(a) % (256 << RM[k]);
    logic [15:0] r = '0;
    for (int j = 0; j < w; j++) r[lane(RM[k], j)] = m[k][wa*w+j];
    return r;
  endfunction
  task automatic mwrite(input int k, input logic [10:0] a, input logic [15:0] d, input logic [15:0] mk);
    int w = 16 >> WM[k];
    int wa = int'(a) % (256 << WM[k]);
    bit mask_on = 0;
`ifdef SB_RAM_WRITE_MASK_EN
    mask_on = WM[k] == 0;
`endif
    for (int j = 0; j < w; j++) if (!(mask_on && mk[j])) m[k][wa*w+j] = d[lane(WM[k], j)];
  endtask
  task automatic step(input logic rs, input logic r_en, input logic r_ck, input logic [10:0] ra,
                      input logic w_en, input logic w_ck, input logic [10:0] wa,
                      input logic [15:0] wd, input logic [15:0] mk);
    @(negedge clk);
    rst = rs; re = r_en; rclke = r_ck; raddr = ra; we = w_en; wclke = w_ck; waddr = wa; wdata = wd; mask = mk;
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      if (rs) rexp[k] = '0;
      else if (r_en && r_ck) rexp[k] = mread(k, ra);
      if (!rs && w_en && w_ck) mwrite(k, wa, wd, mk);
    end
    #1;
    for (int k = 0; k < 4; k++) chk($sformatf("model_u%0d", k), rd[k], rexp[k]);
  endtask
  task automatic rd_at(input logic [10:0] a);
    step(0, 1, 1, a, 0, 0, 0, 0, 0);
  endtask
  task automatic wr_at(input logic [10:0] a, input logic [15:0] d, input logic [15:0] mk);
    step(0, 0, 1, 0, 1, 1, a, d, mk);
  endtask
  initial begin
    for (int k = 0; k < 4; k++) begin
      rexp[k] = '0;
      for (int b = 0; b < 4096; b++) m[k][b] = 0;
    end
    for (int b = 0; b < 256; b++) begin
      m[1][b] = INIT1[b];
      m[2][1280+b] = INIT2[b];
    end
    step(1, 1, 1, 0, 0, 0, 0, 0, 0);
    chk("reset_u0", rd[0], 16'h0000);
    rd_at(0);
    chk("init_mode3_a0", rd[1], 16'h0808);
    rd_at(128);
    chk("init_mode3_a128", rd[1], 16'h0000);
    wr_at(5, 16'hA55A, 0);
    rd_at(5);
    chk("write_read_a5", rd[0], 16'hA55A);
    step(0, 1, 1, 7, 1, 1, 7, 16'h1234, 0);
    chk("same_edge_old", rd[0], 16'h0000);
    rd_at(7);
    chk("same_edge_new", rd[0], 16'h1234);
    wr_at(9, 16'hFFFF, 0);
    step(1, 1, 1, 9, 1, 1, 9, 16'h0000, 0);
    chk("rst_read_zero", rd[0], 16'h0000);
    rd_at(9);
    chk("rst_blocks_write", rd[0], 16'hFFFF);
    step(0, 0, 1, 9, 0, 0, 0, 0, 0);
    chk("hold_re0", rd[0], 16'hFFFF);
    step(0, 1, 0, 5, 0, 0, 0, 0, 0);
    chk("hold_rclke0", rd[0], 16'hFFFF);
    wr_at(11, 16'h0000, 0);
    wr_at(11, 16'hFFFF, 16'hFF00);
    rd_at(11);
`ifdef SB_RAM_WRITE_MASK_EN
    chk("mask_write", rd[0], 16'h00FF);
`else
    chk("mask_write", rd[0], 16'hFFFF);
`endif
    wr_at(0, 16'h0000, 0);
    wr_at(0, 16'h0003, 0);
    rd_at(0);
    chk("mixed_a0", rd[1], 16'h0808);
    rd_at(1);
    chk("mixed_a1", rd[1], 16'h0000);
    rd_at(11'h405);
    chk("wrap_a5", rd[0], 16'hA55A);
    for (int i = 0; i < 400; i++)
      step($urandom_range(15) == 0, $urandom_range(3) != 0, $urandom_range(7) != 0,
           11'($urandom), $urandom_range(1), $urandom_range(7) != 0,
           $urandom_range(1) ? 11'($urandom_range(15)) : 11'($urandom),
           16'($urandom), 16'($urandom));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
